// File: rtl/tx_packet_assembler.sv
// Transmit packet assembler: frames payload as STP/payload/END and emits SKP, TS1, TS2
// and EIOS ordered sets as a BYTES-wide K/D character stream with registered outputs.
module tx_packet_assembler #(
    parameter int BYTES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8*BYTES-1:0] in_data_i,
    input  logic               in_valid_i,
    input  logic               in_last_i,
    output logic               in_ready_o,
    input  logic               os_req_i,
    input  logic [1:0]         os_type_i,
    input  logic [7:0]         ts_link_i,
    input  logic [7:0]         ts_lane_i,
    input  logic [7:0]         ts_nfts_i,
    input  logic [7:0]         ts_rate_i,
    input  logic [7:0]         ts_ctrl_i,
    output logic               os_ack_o,
    output logic [8*BYTES-1:0] out_data_o,
    output logic [BYTES-1:0]   out_k_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam int         W      = 8*BYTES;
    localparam bit         ONE    = (BYTES == 1);
    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] K_STP  = 8'hFB;
    localparam logic [7:0] K_END  = 8'hFD;
    localparam logic [7:0] K_PAD  = 8'hF7;
    localparam logic [7:0] K_IDL  = 8'h7C;
    localparam logic [7:0] D_TS1  = 8'h4A;
    localparam logic [7:0] D_TS2  = 8'h45;
    localparam logic [3:0] OS_LAST_SHORT = 4'(4/BYTES - 1);
    localparam logic [3:0] OS_LAST_TS    = 4'(16/BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_OS, S_START, S_DATA, S_TAIL} state_t;

    state_t           r_state, w_state_next;
    logic [W-1:0]     r_out_data, w_out_data_next;
    logic [BYTES-1:0] r_out_k, w_out_k_next;
    logic             r_out_valid, w_out_valid_next;
    logic             r_os_ack, w_os_ack_next;
    logic [7:0]       r_carry, w_carry_next;
    logic [3:0]       r_beat, w_beat_next;
    logic             r_os_ts;
    logic [15:0]      r_os_k;
    logic [7:0]       r_os_sym [16];

    logic             w_slot, w_in_fire, w_os_start, w_is_ts, w_os_last;
    logic [7:0]       w_ts_field [5];
    logic [7:0]       w_os_sym [16];
    logic [15:0]      w_os_k;
    logic [W-1:0]     w_os_beat, w_start_beat, w_data_beat, w_tail_beat;
    logic [BYTES-1:0] w_os_beat_k, w_tail_k;
    logic [7:0]       w_carry_in;

    assign w_slot      = !r_out_valid || out_ready_i;
    assign in_ready_o  = w_slot && (((r_state == S_START) && !ONE) || (r_state == S_DATA));
    assign w_in_fire   = in_valid_i && in_ready_o;
    // The cycle carrying os_ack is skipped so a requester dropping os_req after it is not re-served.
    assign w_os_start  = (r_state == S_IDLE) && os_req_i && !r_os_ack;
    assign w_is_ts     = (os_type_i == 2'd1) || (os_type_i == 2'd2);
    assign w_os_last   = (r_beat == (r_os_ts ? OS_LAST_TS : OS_LAST_SHORT));
    assign w_carry_in  = in_data_i[W-1 -: 8];
    assign w_ts_field  = '{ts_link_i, ts_lane_i, ts_nfts_i, ts_rate_i, ts_ctrl_i};
    assign w_os_k      = {12'h000, {3{!w_is_ts}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_os_sym
            if (gi == 0) begin : g_com
                assign w_os_sym[gi] = K_COM;
            end else if (gi < 4) begin : g_hdr
                assign w_os_sym[gi] = w_is_ts ? w_ts_field[gi-1]
                                    : ((os_type_i == 2'd3) ? K_IDL : K_SKP);
            end else if (gi < 6) begin : g_ts
                assign w_os_sym[gi] = w_ts_field[gi-1];
            end else begin : g_fill
                assign w_os_sym[gi] = (os_type_i == 2'd2) ? D_TS2 : D_TS1;
            end
        end

        for (gi = 0; gi < BYTES; gi++) begin : g_os_beat
            assign w_os_beat[8*gi +: 8] = r_os_sym[r_beat*4'(BYTES) + 4'(gi)];
            assign w_os_beat_k[gi]      = r_os_k[r_beat*4'(BYTES) + 4'(gi)];
        end

        // STP occupies byte 0, so every later beat is the input shifted up by one byte.
        if (BYTES == 1) begin : g_w1
            assign w_start_beat = K_STP;
            assign w_data_beat  = in_data_i;
            assign w_tail_beat  = K_END;
            assign w_tail_k     = 1'b1;
        end else begin : g_wn
            assign w_start_beat = {in_data_i[W-9:0], K_STP};
            assign w_data_beat  = {in_data_i[W-9:0], r_carry};
            assign w_tail_k     = {{(BYTES-1){1'b1}}, 1'b0};
            if (BYTES == 2) begin : g_t2
                assign w_tail_beat = {K_END, r_carry};
            end else begin : g_t4
                assign w_tail_beat = {{(BYTES-2){K_PAD}}, K_END, r_carry};
            end
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_out_data_next  = r_out_data;
        w_out_k_next     = r_out_k;
        w_out_valid_next = r_out_valid;
        w_os_ack_next    = 1'b0;
        w_carry_next     = r_carry;
        w_beat_next      = r_beat;
        case (r_state)
            S_IDLE: begin
                if (w_slot) w_out_valid_next = 1'b0;
                if (w_os_start) begin
                    w_state_next = S_OS;
                    w_beat_next  = 4'd0;
                end else if (in_valid_i) begin
                    w_state_next = S_START;
                end
            end
            S_OS: begin
                if (w_slot) begin
                    w_out_data_next  = w_os_beat;
                    w_out_k_next     = w_os_beat_k;
                    w_out_valid_next = 1'b1;
                    if (w_os_last) begin
                        w_os_ack_next = 1'b1;
                        w_beat_next   = 4'd0;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_beat_next = r_beat + 4'd1;
                    end
                end
            end
            S_START: begin
                if (ONE) begin
                    if (w_slot) begin
                        w_out_data_next  = w_start_beat;
                        w_out_k_next     = BYTES'(1);
                        w_out_valid_next = 1'b1;
                        w_state_next     = S_DATA;
                    end
                end else if (w_in_fire) begin
                    w_out_data_next  = w_start_beat;
                    w_out_k_next     = BYTES'(1);
                    w_out_valid_next = 1'b1;
                    w_carry_next     = w_carry_in;
                    w_state_next     = in_last_i ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (w_in_fire) begin
                    w_out_data_next  = w_data_beat;
                    w_out_k_next     = '0;
                    w_out_valid_next = 1'b1;
                    w_carry_next     = w_carry_in;
                    if (in_last_i) w_state_next = S_TAIL;
                end else if (w_slot) begin
                    w_out_valid_next = 1'b0;
                end
            end
            S_TAIL: begin
                if (w_slot) begin
                    w_out_data_next  = w_tail_beat;
                    w_out_k_next     = w_tail_k;
                    w_out_valid_next = 1'b1;
                    w_state_next     = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_out_data  <= '0;
            r_out_k     <= '0;
            r_out_valid <= 1'b0;
            r_os_ack    <= 1'b0;
            r_carry     <= 8'h00;
            r_beat      <= 4'd0;
            r_os_ts     <= 1'b0;
            r_os_k      <= 16'h0000;
            for (int i = 0; i < 16; i++) r_os_sym[i] <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_out_data  <= w_out_data_next;
            r_out_k     <= w_out_k_next;
            r_out_valid <= w_out_valid_next;
            r_os_ack    <= w_os_ack_next;
            r_carry     <= w_carry_next;
            r_beat      <= w_beat_next;
            if (w_os_start) begin
                r_os_ts <= w_is_ts;
                r_os_k  <= w_os_k;
                for (int i = 0; i < 16; i++) r_os_sym[i] <= w_os_sym[i];
            end
        end
    end

    assign out_data_o  = r_out_data;
    assign out_k_o     = r_out_k;
    assign out_valid_o = r_out_valid;
    assign os_ack_o    = r_os_ack;

endmodule

// File: tb/tb_tx_packet_assembler.sv
// Scoreboard bench for tx_packet_assembler at BYTES=4 (ordered sets, frames, stalls)
// and BYTES=1 (frame and mid-frame reset).
module tb_tx_packet_assembler;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        ack;
    } exp_t;

    logic        clk = 0;
    logic        rst, rst1;
    logic [31:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic        os_req, os_ack;
    logic [1:0]  os_type;
    logic [7:0]  ts_link, ts_lane, ts_nfts, ts_rate, ts_ctrl;
    logic [31:0] out_data;
    logic [3:0]  out_k;
    logic        out_valid, out_ready;

    logic [7:0]  in_data1, out_data1;
    logic        in_valid1, in_last1, in_ready1, out_k1, out_valid1, out_ready1, os_ack1;
    logic        os_req1;
    logic [1:0]  os_type1;
    logic [7:0]  ts_zero;

    exp_t        q4[$];
    exp_t        q1[$];
    logic [7:0]  pay [0:15];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    bit          mon1_en  = 1;
    logic        pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    tx_packet_assembler #(.BYTES(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
        .os_req_i(os_req), .os_type_i(os_type),
        .ts_link_i(ts_link), .ts_lane_i(ts_lane), .ts_nfts_i(ts_nfts),
        .ts_rate_i(ts_rate), .ts_ctrl_i(ts_ctrl),
        .os_ack_o(os_ack), .out_data_o(out_data), .out_k_o(out_k),
        .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    tx_packet_assembler #(.BYTES(1)) dut1 (
        .clk_i(clk), .rst_i(rst1),
        .in_data_i(in_data1), .in_valid_i(in_valid1), .in_last_i(in_last1), .in_ready_o(in_ready1),
        .os_req_i(os_req1), .os_type_i(os_type1),
        .ts_link_i(ts_zero), .ts_lane_i(ts_zero), .ts_nfts_i(ts_zero),
        .ts_rate_i(ts_zero), .ts_ctrl_i(ts_zero),
        .os_ack_o(os_ack1), .out_data_o(out_data1), .out_k_o(out_k1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: STP, payload, END, PAD to a whole beat, then cut into beats.
    task automatic model_frame(input int w, input int n);
        logic [7:0] b[$];
        bit         kb[$];
        exp_t       e;
        b.push_back(8'hFB); kb.push_back(1'b1);
        for (int i = 0; i < n; i++) begin b.push_back(pay[i]); kb.push_back(1'b0); end
        b.push_back(8'hFD); kb.push_back(1'b1);
        while ((b.size() % w) != 0) begin b.push_back(8'hF7); kb.push_back(1'b1); end
        for (int i = 0; i < b.size(); i += w) begin
            e = '0;
            for (int j = 0; j < w; j++) begin
                e.d[8*j +: 8] = b[i+j];
                e.k[j]        = kb[i+j];
            end
            if (w == 4) q4.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic model_os(input logic [1:0] t, input logic [7:0] l, ln, nf, rt, ct);
        logic [7:0] b[$];
        bit         kb[$];
        exp_t       e;
        b.push_back(8'hBC); kb.push_back(1'b1);
        if (t == 2'd0 || t == 2'd3) begin
            for (int i = 0; i < 3; i++) begin
                b.push_back((t == 2'd0) ? 8'h1C : 8'h7C); kb.push_back(1'b1);
            end
        end else begin
            b.push_back(l);  b.push_back(ln); b.push_back(nf);
            b.push_back(rt); b.push_back(ct);
            for (int i = 0; i < 10; i++) b.push_back((t == 2'd1) ? 8'h4A : 8'h45);
            for (int i = 0; i < 15; i++) kb.push_back(1'b0);
        end
        for (int i = 0; i < b.size(); i += 4) begin
            e = '0;
            for (int j = 0; j < 4; j++) begin
                e.d[8*j +: 8] = b[i+j];
                e.k[j]        = kb[i+j];
            end
            e.ack = (i + 4 >= b.size());
            q4.push_back(e);
        end
    endtask

    task automatic wait_accept(input bit narrow);
        int cyc = 0;
        bit acc = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = narrow ? (in_ready1 && in_valid1) : (in_ready && in_valid);
            @(posedge clk); #1;
            cyc++;
        end
        check(narrow ? "in_accept1" : "in_accept4", acc, 1);
    endtask

    task automatic drive_pkt4(input int n);
        for (int bt = 0; bt < n/4; bt++) begin
            for (int j = 0; j < 4; j++) in_data[8*j +: 8] = pay[4*bt + j];
            in_valid = 1'b1;
            in_last  = (bt == n/4 - 1);
            wait_accept(1'b0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drive_pkt1(input int n);
        for (int i = 0; i < n; i++) begin
            in_data1  = pay[i];
            in_valid1 = 1'b1;
            in_last1  = (i == n - 1);
            wait_accept(1'b1);
        end
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
    endtask

    task automatic do_os(input logic [1:0] t, input logic [7:0] l, ln, nf, rt, ct, input bit scramble);
        int cyc  = 0;
        bit seen = 0;
        model_os(t, l, ln, nf, rt, ct);
        os_type = t; ts_link = l; ts_lane = ln; ts_nfts = nf; ts_rate = rt; ts_ctrl = ct;
        os_req  = 1'b1;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            seen = os_ack;
            @(posedge clk); #1;
            cyc++;
            if (scramble && cyc == 1) begin
                os_type = ~t;
                ts_link = 8'hEE; ts_lane = 8'hEE; ts_nfts = 8'hEE; ts_rate = 8'hEE; ts_ctrl = 8'hEE;
            end
        end
        os_req = 1'b0;
        check("os_ack_seen", seen, 1);
    endtask

    task automatic drain();
        int c = 0;
        while ((q4.size() != 0 || q1.size() != 0) && c < 200) begin
            @(posedge clk);
            c++;
        end
        check("drain_q4", q4.size(), 0);
        check("drain_q1", q1.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic        stall_prev4 = 0;
    logic [31:0] hold_d4;
    logic [3:0]  hold_k4;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev4 = 0;
        end else begin
            if (stall_prev4) begin
                check("stall_valid4", out_valid, 1);
                check("stall_data4", out_data, hold_d4);
                check("stall_k4", out_k, hold_k4);
            end
            if (out_valid && out_ready) begin
                check("beat_expected4", q4.size() != 0, 1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("beat_data4", out_data, e.d);
                    check("beat_k4", out_k, e.k);
                    check("beat_ack4", os_ack, e.ack);
                end
            end else begin
                check("ack_quiet4", os_ack, 0);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready4", in_ready, 0);
                stall_prev4 = 1;
                hold_d4     = out_data;
                hold_k4     = out_k;
            end else begin
                stall_prev4 = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst1 && mon1_en && out_valid1 && out_ready1) begin
            check("beat_expected1", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("beat_data1", out_data1, e.d[7:0]);
                check("beat_k1", out_k1, e.k[0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; rst1 = 1;
        in_data = '0; in_valid = 0; in_last = 0;
        os_req = 0; os_type = 0;
        ts_link = 0; ts_lane = 0; ts_nfts = 0; ts_rate = 0; ts_ctrl = 0;
        out_ready = 1;
        in_data1 = '0; in_valid1 = 0; in_last1 = 0; out_ready1 = 1;
        os_req1 = 0; os_type1 = 0; ts_zero = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid4", out_valid, 0);
        check("rst_out_data4", out_data, 0);
        check("rst_out_k4", out_k, 0);
        check("rst_os_ack4", os_ack, 0);
        check("rst_in_ready4", in_ready, 0);
        check("rst_out_valid1", out_valid1, 0);
        @(posedge clk); #1;
        rst = 0; rst1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid4", out_valid, 0);

        do_os(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        drain();
        do_os(2'd1, 8'h00, 8'h03, 8'hFF, 8'h02, 8'h00, 1'b1);
        drain();
        do_os(2'd2, 8'h01, 8'h02, 8'h10, 8'h04, 8'h08, 1'b1);
        drain();
        do_os(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) pay[i] = 8'(8'h11 * (i + 1));
        model_frame(4, 8);
        drive_pkt4(8);
        drain();

        model_frame(4, 8);
        fork
            drive_pkt4(8);
            begin
                for (int i = 0; i < 24; i++) begin
                    out_ready = pat[i % 4];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 12; i++) pay[i] = 8'(8'hA1 + i);
        model_frame(4, 12);
        fork
            drive_pkt4(12);
            begin
                @(posedge clk); #1;
                do_os(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
            end
        join
        drain();

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        model_frame(1, 4);
        drive_pkt1(4);
        drain();

        mon1_en   = 0;
        in_data1  = 8'h55;
        in_valid1 = 1'b1;
        in_last1  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_frame_valid1", out_valid1, 1);
        @(posedge clk); #1;
        rst1      = 1'b1;
        in_valid1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid1", out_valid1, 0);
        check("midrst_in_ready1", in_ready1, 0);
        check("midrst_out_k1", out_k1, 0);
        check("midrst_os_ack1", os_ack1, 0);
        @(posedge clk); #1;
        rst1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon1_en = 1;
        pay[0] = 8'h9A; pay[1] = 8'hBC; pay[2] = 8'hDE; pay[3] = 8'hF0;
        model_frame(1, 4);
        drive_pkt1(4);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
